// File: rtl/matrix_uart_printer_if.sv
// Byte-stream and matrix-store read bus for matrix_uart_printer.
//   master (printer side): drives rd_en/rd_addr and tx_byte/tx_valid,
//                          receives rd_data and tx_ready.
//   slave  (store + uart_tx side): the mirror image.
// rd_data is valid exactly one cycle after rd_en. A byte transfers on
// tx_valid && tx_ready.
interface matrix_uart_printer_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        tx_byte;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output rd_en, rd_addr, tx_byte, tx_valid,
                   input  rd_data, tx_ready);
   modport slave  (input  rd_en, rd_addr, tx_byte, tx_valid,
                   output rd_data, tx_ready);
endinterface

// File: rtl/matrix_uart_printer.sv
// Reads an m x n row-major matrix from the matrix store and streams it as
// ASCII decimal text: elements separated by single spaces, each row ended
// by CR LF. Element values above 16 bits print as 65535.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  block enable; low aborts to IDLE
//   start               one-cycle request, sampled only in IDLE
//   dim_m, dim_n        row / column count, legal 1..MAX_DIM
//   base_addr           address of element (0,0)
//   busy, done, err     status: busy span, completion pulse, reject pulse
//   bus (master)        matrix-store read port and tx byte stream
module matrix_uart_printer #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int MAX_DIM = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  start,
   input  logic [2:0]            dim_m,
   input  logic [2:0]            dim_n,
   input  logic [ADDR_W-1:0]     base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   matrix_uart_printer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, FETCH, WAIT_RD, CONV, SEND_SEP, SEND_CR, SEND_LF, DONE
   } state_e;

   localparam logic [2:0] MAX_D = 3'(MAX_DIM);

   state_e            state_q;
   logic [2:0]        m_q, n_q, row_q, col_q;
   logic [ADDR_W-1:0] base_q, rd_addr_q;
   logic              rd_en_q, tx_valid_q, busy_q, done_q, err_q;
   logic [7:0]        tx_byte_q;
   logic [15:0]       val_q;     // remainder still to be converted
   logic [2:0]        pl_q;      // place index: 0 -> 10000 ... 4 -> 1
   logic [3:0]        dig_q;     // digit count for the current place
   logic              lead_q;    // a digit of this element was already sent

   logic              xfer, dims_ok;
   logic [15:0]       place, sat;
   logic [ADDR_W-1:0] addr_next_col, addr_next_row;

   assign xfer    = tx_valid_q & bus.tx_ready;
   assign dims_ok = (dim_m != 3'd0) && (dim_m <= MAX_D) &&
                    (dim_n != 3'd0) && (dim_n <= MAX_D);
   assign sat     = (bus.rd_data[DATA_W-1:16] == '0) ? bus.rd_data[15:0] : 16'hFFFF;

   // Addresses of the element after the current one, within and across rows.
   assign addr_next_col = base_q + ADDR_W'(row_q) * ADDR_W'(n_q)
                          + ADDR_W'(col_q) + ADDR_W'(1);
   assign addr_next_row = base_q + (ADDR_W'(row_q) + ADDR_W'(1)) * ADDR_W'(n_q);

   always_comb begin
      place = 16'd1;
      case (pl_q)
         3'd0:    place = 16'd10000;
         3'd1:    place = 16'd1000;
         3'd2:    place = 16'd100;
         3'd3:    place = 16'd10;
         default: place = 16'd1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         m_q        <= '0;
         n_q        <= '0;
         row_q      <= '0;
         col_q      <= '0;
         base_q     <= '0;
         rd_addr_q  <= '0;
         rd_en_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_byte_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         val_q      <= '0;
         pl_q       <= '0;
         dig_q      <= '0;
         lead_q     <= 1'b0;
      end else if (!en) begin
         // Abort: a byte on the wire this cycle still transfers downstream.
         state_q    <= IDLE;
         rd_en_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (dims_ok) begin
                     m_q       <= dim_m;
                     n_q       <= dim_n;
                     base_q    <= base_addr;
                     row_q     <= '0;
                     col_q     <= '0;
                     busy_q    <= 1'b1;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= base_addr;
                     state_q   <= FETCH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            FETCH: state_q <= WAIT_RD;
            WAIT_RD: begin
               val_q   <= sat;
               pl_q    <= '0;
               dig_q   <= '0;
               lead_q  <= 1'b0;
               state_q <= CONV;
            end
            CONV: begin
               if (tx_valid_q) begin
                  if (bus.tx_ready) begin
                     if (pl_q == 3'd4) begin
                        // Units digit gone: present the separator right away.
                        if (col_q < n_q - 3'd1) begin
                           tx_byte_q <= 8'h20;
                           state_q   <= SEND_SEP;
                        end else begin
                           tx_byte_q <= 8'h0D;
                           state_q   <= SEND_CR;
                        end
                     end else begin
                        tx_valid_q <= 1'b0;
                        pl_q       <= pl_q + 3'd1;
                        dig_q      <= '0;
                     end
                  end
               end else if (val_q >= place) begin
                  val_q <= val_q - place;
                  dig_q <= dig_q + 4'd1;
               end else if (dig_q != 4'd0 || lead_q || pl_q == 3'd4) begin
                  tx_byte_q  <= 8'h30 + {4'd0, dig_q};
                  tx_valid_q <= 1'b1;
                  lead_q     <= 1'b1;
               end else begin
                  pl_q <= pl_q + 3'd1;   // leading zero suppressed
               end
            end
            SEND_SEP: begin
               if (xfer) begin
                  tx_valid_q <= 1'b0;
                  col_q      <= col_q + 3'd1;
                  rd_en_q    <= 1'b1;
                  rd_addr_q  <= addr_next_col;
                  state_q    <= FETCH;
               end
            end
            SEND_CR: begin
               if (xfer) begin
                  tx_byte_q <= 8'h0A;
                  state_q   <= SEND_LF;
               end
            end
            SEND_LF: begin
               if (xfer) begin
                  tx_valid_q <= 1'b0;
                  if (row_q < m_q - 3'd1) begin
                     row_q     <= row_q + 3'd1;
                     col_q     <= '0;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= addr_next_row;
                     state_q   <= FETCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.tx_byte  = tx_byte_q;
   assign bus.tx_valid = tx_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule
